alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one 64-bit combinational add/sub unit between two requesters: port 0 = execute stage, port 1 = address/branch-compare logic.
- Round-robin arbitration, valid/ready handshake on each request port, and a held response per port.
- Drives the shared unit's operand and opcode inputs from registers; captures its Sum/Diff and Overflow outputs.
- Sits beside the pipeline ALU; the add/sub unit itself stays external.

Parameters:
- W, 64, operand/result width.
- CNT_W, 32, width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_ready  out  2  per-port request accept.
- req_op  in  2  per-port opcode: 0 = add, 1 = sub (A - B).
- req_a0, req_b0  in  W each  port 0 operands (signed).
- req_a1, req_b1  in  W each  port 1 operands (signed).
- rsp_valid  out  2  per-port response valid.
- rsp_ready  in  2  per-port response accept.
- rsp_result  out  W  result of the in-flight operation (shared by both ports).
- rsp_ovf  out  1  signed overflow of that result.
- alu_a, alu_b  out  W each  operands to the shared unit.
- alu_sub  out  1  selects the shared unit's subtract path.
- alu_sum  in  W  shared unit result (combinational).
- alu_ovf  in  1  shared unit overflow (combinational).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, priority pointer=port 0.
  - req_ready=0, rsp_valid=0, rsp_result=0, rsp_ovf=0.
  - alu_a=0, alu_b=0, alu_sub=0.
  - Reset mid-operation discards the in-flight op and any pending response; no response is emitted afterwards.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational: only the winning port's bit is 1; the winner is chosen from req_valid and the priority pointer.
  - Both valid: grant goes to the pointer port. One valid: grant goes to that port.
  - On handshake (valid & ready): latch that port's A, B and op into alu_a/alu_b/alu_sub, record owner, go to EXEC.
  - Pointer moves to the other port after every grant.
- EXEC: one cycle. alu_* are stable from registers; capture alu_sum into rsp_result and alu_ovf into rsp_ovf at the cycle end; go to RESP.
- RESP:
  - rsp_valid[owner]=1; the other bit stays 0.
  - rsp_result and rsp_ovf are held stable until rsp_ready[owner]=1.
  - On that handshake, the next state is IDLE.
  - rsp_ready on the non-owner bit is ignored.
- req_ready=0 in EXEC and RESP; no new grant before the response handshake completes.
- Latency: request handshake at edge N, rsp_valid high from N+2. Best-case throughput is one op per 3 cycles.
- Arithmetic:
  - Result is two's-complement, modulo 2^W.
  - rsp_ovf is the shared unit's signed overflow, passed through unmodified.
  - The block performs no arithmetic itself.
- Requesters may drop req_valid without a handshake; no state change results.
- req_op, A and B are sampled only at the handshake edge.
- alu_* hold their last values in IDLE and RESP; there is no toggling between ops.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, three extra ports are added:
  - grant_cnt0 (out, CNT_W): completed grants to port 0.
  - grant_cnt1 (out, CNT_W): completed grants to port 1.
  - contention_cnt (out, CNT_W): cycles in IDLE with both req_valid bits set.
- Counters increment at the request handshake edge and wrap at 2^CNT_W. rst clears them to 0.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then req_valid=00 -> req_ready=00, rsp_valid=00, alu_a=0, rsp_result=0.
- Single add on port 0: A=5, B=7, op=0, handshake at N -> rsp_valid=01 at N+2, rsp_result=12, rsp_ovf=0; held 3 cycles with rsp_ready=0, then released.
- Subtract overflow on port 1: A=0x8000000000000000, B=1, op=1 -> rsp_result=0x7FFFFFFFFFFFFFFF, rsp_ovf=1, rsp_valid=10.
- Contention: both ports valid continuously, rsp_ready=11 -> grants alternate 0,1,0,1; each port gets its correct result.
- Reset mid-operation: rst asserted in EXEC -> next cycle IDLE, rsp_valid=00, pointer=0, no stale response appears.
- With ALU_ARB_STATS_EN: 3 contended grants and 1 uncontended grant to port 0 -> grant_cnt0=3, grant_cnt1=1 plus the contended alternation pattern, contention_cnt equals the counted contended IDLE cycles; counters hold after traffic stops.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external 64-bit combinational add/sub unit between two
// requesters: port 0 (execute stage) and port 1 (address/branch-compare).
// Each request port uses a valid/ready handshake, and arbitration is
// round-robin. Operands and the opcode are driven to the shared unit from
// registers. The unit's result and overflow are captured and held as a
// per-port response until the owning port accepts it.
//
// Ports:
//   clk, rst            single clock; synchronous active-high reset
//   req_valid/req_ready per-port request handshake (bit i = port i)
//   req_op              per-port opcode: 0 = add, 1 = sub (A - B)
//   req_a0/req_b0       port 0 operands
//   req_a1/req_b1       port 1 operands
//   rsp_valid/rsp_ready per-port response handshake
//   rsp_result/rsp_ovf  captured result and signed overflow (shared)
//   alu_a/alu_b/alu_sub registered drive to the shared unit
//   alu_sum/alu_ovf     shared unit outputs (combinational)
//
// Optional feature (macro ALU_ARB_STATS_EN): adds the statistics counters
// grant_cnt0, grant_cnt1 and contention_cnt (CNT_W bits each, wrapping).
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int W     = 64,
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [1:0]     req_op,
    input  logic [W-1:0]   req_a0,
    input  logic [W-1:0]   req_b0,
    input  logic [W-1:0]   req_a1,
    input  logic [W-1:0]   req_b1,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [W-1:0]   rsp_result,
    output logic           rsp_ovf,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic           alu_sub,
    input  logic [W-1:0]   alu_sum,
    input  logic           alu_ovf
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
    output logic [CNT_W-1:0] contention_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_r;
    state_t         next_state_s;
    logic           ptr_r;        // port that wins when both request
    logic           owner_r;      // port that owns the in-flight op
    logic           win_s;
    logic           grant_s;
    logic           req_hs_s;
    logic           rsp_hs_s;
    logic [W-1:0]   alu_a_r;
    logic [W-1:0]   alu_b_r;
    logic           alu_sub_r;
    logic [W-1:0]   rsp_result_r;
    logic           rsp_ovf_r;
    logic [1:0]     rsp_valid_r;

    // Round-robin winner selection from the current request vector
    always_comb begin
        win_s   = 1'b0;
        grant_s = 1'b0;
        case (req_valid)
            2'b01: begin
                win_s   = 1'b0;
                grant_s = 1'b1;
            end
            2'b10: begin
                win_s   = 1'b1;
                grant_s = 1'b1;
            end
            2'b11: begin
                win_s   = ptr_r;
                grant_s = 1'b1;
            end
            default: begin
                win_s   = 1'b0;
                grant_s = 1'b0;
            end
        endcase
    end

    // Handshake qualifiers; ready is only offered in IDLE to the winner
    always_comb begin
        req_ready = 2'b00;
        req_hs_s  = 1'b0;
        rsp_hs_s  = 1'b0;
        if ((state_r == ST_IDLE) && grant_s) begin
            req_ready = win_s ? 2'b10 : 2'b01;
            req_hs_s  = 1'b1;
        end else begin
            req_ready = 2'b00;
            req_hs_s  = 1'b0;
        end
        // Only the owner's rsp_ready completes the response
        if (state_r == ST_RESP) begin
            rsp_hs_s = rsp_ready[owner_r];
        end else begin
            rsp_hs_s = 1'b0;
        end
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_hs_s) begin
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                next_state_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_hs_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Grant bookkeeping, operand latch, result capture and response flag
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r        <= 1'b0;
            owner_r      <= 1'b0;
            alu_a_r      <= '0;
            alu_b_r      <= '0;
            alu_sub_r    <= 1'b0;
            rsp_result_r <= '0;
            rsp_ovf_r    <= 1'b0;
            rsp_valid_r  <= 2'b00;
        end else begin
            if (req_hs_s) begin
                // Operands are sampled only here; alu_* then hold until the next grant
                alu_a_r   <= win_s ? req_a1 : req_a0;
                alu_b_r   <= win_s ? req_b1 : req_b0;
                alu_sub_r <= req_op[win_s];
                owner_r   <= win_s;
                ptr_r     <= ~win_s;
            end
            if (state_r == ST_EXEC) begin
                rsp_result_r <= alu_sum;
                rsp_ovf_r    <= alu_ovf;
                rsp_valid_r  <= owner_r ? 2'b10 : 2'b01;
            end else if (rsp_hs_s) begin
                rsp_valid_r  <= 2'b00;
            end else begin
                rsp_valid_r  <= rsp_valid_r;
            end
        end
    end

    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_sub    = alu_sub_r;
    assign rsp_result = rsp_result_r;
    assign rsp_ovf    = rsp_ovf_r;
    assign rsp_valid  = rsp_valid_r;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt0_r;
    logic [CNT_W-1:0] grant_cnt1_r;
    logic [CNT_W-1:0] contention_cnt_r;

    // Statistics counters; they wrap naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0_r     <= '0;
            grant_cnt1_r     <= '0;
            contention_cnt_r <= '0;
        end else begin
            if (req_hs_s && !win_s) begin
                grant_cnt0_r <= grant_cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (req_hs_s && win_s) begin
                grant_cnt1_r <= grant_cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            // Both valid in IDLE always produces a grant, so this is a handshake edge too
            if ((state_r == ST_IDLE) && (req_valid == 2'b11)) begin
                contention_cnt_r <= contention_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign grant_cnt0     = grant_cnt0_r;
    assign grant_cnt1     = grant_cnt1_r;
    assign contention_cnt = contention_cnt_r;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed, self-checking bench for alu_share_arbiter. The bench supplies the
// external add/sub unit. Expected results are hand-computed constants.
// The statistics checks are compiled in when ALU_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req_op;
    logic [63:0]  req_a0, req_b0, req_a1, req_b1;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [63:0]  rsp_result;
    logic         rsp_ovf;
    logic [63:0]  alu_a, alu_b;
    logic         alu_sub;
    logic [63:0]  alu_sum;
    logic         alu_ovf;
`ifdef ALU_ARB_STATS_EN
    logic [31:0]  grant_cnt0, grant_cnt1, contention_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.W(64), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_ovf    (rsp_ovf),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sub    (alu_sub),
        .alu_sum    (alu_sum),
        .alu_ovf    (alu_ovf)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0     (grant_cnt0),
        .grant_cnt1     (grant_cnt1),
        .contention_cnt (contention_cnt)
`endif
    );

    // External shared add/sub unit with signed overflow
    always_comb begin
        alu_sum = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
        if (alu_sub) begin
            alu_ovf = (alu_a[63] != alu_b[63]) && (alu_sum[63] != alu_a[63]);
        end else begin
            alu_ovf = (alu_a[63] == alu_b[63]) && (alu_sum[63] != alu_a[63]);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full op with rsp_ready held high: IDLE grant, EXEC, RESP, back to IDLE
    task automatic run_op(input string tag, input logic [1:0] exp_port,
                          input logic [63:0] exp_res, input logic exp_ovf);
        #1;
        check_val({tag, "_ready"}, {62'd0, req_ready}, {62'd0, exp_port});
        tick();
        tick();
        check_val({tag, "_rsp_valid"}, {62'd0, rsp_valid}, {62'd0, exp_port});
        check_val({tag, "_result"}, rsp_result, exp_res);
        check_val({tag, "_ovf"}, {63'd0, rsp_ovf}, {63'd0, exp_ovf});
        tick();
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_op = 2'b00; rsp_ready = 2'b00;
        req_a0 = 64'd0; req_b0 = 64'd0; req_a1 = 64'd0; req_b1 = 64'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        #1;
        check_val("rst_req_ready", {62'd0, req_ready}, 64'd0);
        check_val("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        check_val("rst_alu_a", alu_a, 64'd0);
        check_val("rst_alu_b", alu_b, 64'd0);
        check_val("rst_alu_sub", {63'd0, alu_sub}, 64'd0);
        check_val("rst_result", rsp_result, 64'd0);
        check_val("rst_ovf", {63'd0, rsp_ovf}, 64'd0);

        // Single add on port 0: 5 + 7 = 12
        req_valid = 2'b01; req_a0 = 64'd5; req_b0 = 64'd7; req_op = 2'b00;
        #1;
        check_val("add_ready", {62'd0, req_ready}, 64'd1);
        tick();
        req_valid = 2'b00;
        check_val("add_exec_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        check_val("add_exec_ready", {62'd0, req_ready}, 64'd0);
        check_val("add_alu_a", alu_a, 64'd5);
        check_val("add_alu_b", alu_b, 64'd7);
        check_val("add_alu_sub", {63'd0, alu_sub}, 64'd0);
        tick();
        check_val("add_rsp_valid", {62'd0, rsp_valid}, 64'd1);
        check_val("add_result", rsp_result, 64'd12);
        check_val("add_ovf", {63'd0, rsp_ovf}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("add_hold_valid", {62'd0, rsp_valid}, 64'd1);
            check_val("add_hold_result", rsp_result, 64'd12);
            check_val("add_hold_alu_a", alu_a, 64'd5);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        check_val("add_released", {62'd0, rsp_valid}, 64'd0);

        // Subtract overflow on port 1: min_int - 1
        req_valid = 2'b10; req_a1 = 64'h8000_0000_0000_0000; req_b1 = 64'd1; req_op = 2'b10;
        #1;
        check_val("sub_ready", {62'd0, req_ready}, 64'd2);
        tick();
        req_valid = 2'b00;
        check_val("sub_alu_sub", {63'd0, alu_sub}, 64'd1);
        tick();
        check_val("sub_rsp_valid", {62'd0, rsp_valid}, 64'd2);
        check_val("sub_result", rsp_result, 64'h7FFF_FFFF_FFFF_FFFF);
        check_val("sub_ovf", {63'd0, rsp_ovf}, 64'd1);
        rsp_ready = 2'b01;          // non-owner ready must be ignored
        tick();
        check_val("sub_nonowner_ignored", {62'd0, rsp_valid}, 64'd2);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
        check_val("sub_released", {62'd0, rsp_valid}, 64'd0);

        // Contention: 100+1=101 on port 0, 10-3=7 on port 1, alternating 0,1,0,1
        req_a0 = 64'd100; req_b0 = 64'd1; req_a1 = 64'd10; req_b1 = 64'd3; req_op = 2'b10;
        req_valid = 2'b11; rsp_ready = 2'b11;
        run_op("cont0", 2'b01, 64'd101, 1'b0);
        run_op("cont1", 2'b10, 64'd7, 1'b0);
        run_op("cont2", 2'b01, 64'd101, 1'b0);
        run_op("cont3", 2'b10, 64'd7, 1'b0);
        req_valid = 2'b00; rsp_ready = 2'b00;

        // Reset in EXEC: the op is discarded and the pointer returns to port 0
        req_valid = 2'b01; req_a0 = 64'd1; req_b0 = 64'd1; req_op = 2'b00;
        #1;
        tick();
        req_valid = 2'b00;
        check_val("mid_exec_alu_a", alu_a, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        check_val("mid_rst_alu_a", alu_a, 64'd0);
        check_val("mid_rst_result", rsp_result, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("mid_no_stale_rsp", {62'd0, rsp_valid}, 64'd0);
        end
        req_valid = 2'b11;
        #1;
        check_val("mid_ptr_port0", {62'd0, req_ready}, 64'd1);
        // Dropping valid before the edge leaves the block idle
        req_valid = 2'b00;
        tick();
        check_val("drop_no_op", {62'd0, rsp_valid}, 64'd0);
        check_val("drop_alu_a", alu_a, 64'd0);

`ifdef ALU_ARB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("stat_rst_g0", {32'd0, grant_cnt0}, 64'd0);
        check_val("stat_rst_cont", {32'd0, contention_cnt}, 64'd0);
        req_a0 = 64'd2; req_b0 = 64'd3; req_a1 = 64'd9; req_b1 = 64'd4; req_op = 2'b10;
        req_valid = 2'b11; rsp_ready = 2'b11;
        run_op("stat_c0", 2'b01, 64'd5, 1'b0);
        run_op("stat_c1", 2'b10, 64'd5, 1'b0);
        run_op("stat_c2", 2'b01, 64'd5, 1'b0);
        req_valid = 2'b01;
        run_op("stat_u0", 2'b01, 64'd5, 1'b0);
        req_valid = 2'b00; rsp_ready = 2'b00;
        for (int i = 0; i < 4; i++) tick();
        check_val("stat_g0", {32'd0, grant_cnt0}, 64'd3);
        check_val("stat_g1", {32'd0, grant_cnt1}, 64'd1);
        check_val("stat_cont", {32'd0, contention_cnt}, 64'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
